// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch for the single-issue RV32I core: one outstanding
// req/gnt/rvalid transaction to instruction memory, 1-entry valid/ready buffer towards decode.
module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [1:0]      i_B_J_result,
    input  logic [XLEN-1:0] i_target,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_instr_valid,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_instr_ready,
    output logic [1:0]      o_dbg_state
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;

    logic redirect;
    logic buf_free;
    logic req;
    logic unused_bj_hi;

    assign redirect     = i_B_J_result[0];
    assign unused_bj_hi = i_B_J_result[1];

    // Decode handshake: a word transfers on a cycle where o_instr_valid && i_instr_ready and
    // no redirect is present; the output holds stable while valid && !ready.
    assign buf_free = !valid_q || i_instr_ready;
    assign req      = i_rst_n && (state_q == S_REQ) && buf_free;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;

        if (valid_q && i_instr_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (req && i_imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    state_d = S_REQ;
                    valid_d = 1'b1;
                    instr_d = i_imem_rdata;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + XLEN'(4);
                end
            end
            S_FLUSH: begin
                if (i_imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // A redirect squashes the buffered word and any response in flight this cycle;
        // a grant taken alongside it still owes one response, which S_FLUSH swallows.
        if (redirect) begin
            pc_d    = {i_target[XLEN-1:2], 2'b00};
            valid_d = 1'b0;
            instr_d = instr_q;
            ipc_d   = ipc_q;
            case (state_q)
                S_REQ:   state_d = (req && i_imem_gnt) ? S_FLUSH : S_REQ;
                S_WAIT:  state_d = i_imem_rvalid ? S_REQ : S_FLUSH;
                S_FLUSH: state_d = i_imem_rvalid ? S_REQ : S_FLUSH;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP;
            ipc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    assign o_imem_req    = req;
    assign o_imem_addr   = pc_q;
    assign o_instr_valid = valid_q;
    assign o_instr       = instr_q;
    assign o_pc          = ipc_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: scoreboard queues for granted addresses and for words
// delivered to decode, popped by a negedge monitor; direct checks for state and boundaries.
module tb_pc_fetch_unit;
    logic        i_clk;
    logic        i_rst_n;
    logic [1:0]  i_B_J_result;
    logic [31:0] i_target;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_instr_ready;
    logic [1:0]  o_dbg_state;

    localparam logic [31:0] ST_REQ   = 32'd0;
    localparam logic [31:0] ST_WAIT  = 32'd1;
    localparam logic [31:0] ST_FLUSH = 32'd2;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_auto;
    int mem_budget;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_out_q[$];

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_B_J_result  (i_B_J_result),
        .i_target      (i_target),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .i_instr_ready (i_instr_ready),
        .o_dbg_state   (o_dbg_state)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: one clock cycle; auto memory grants up to mem_budget requests, rvalid +1 cycle
    task automatic tick();
        logic        g;
        logic [31:0] ga;
        #1;
        if (mem_auto != 0) i_imem_gnt = o_imem_req && (mem_budget > 0);
        g  = i_imem_gnt && o_imem_req;
        ga = o_imem_addr;
        if (g && mem_auto != 0) mem_budget--;
        @(posedge i_clk);
        #1;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_B_J_result  = 2'b00;
        if (g && mem_auto != 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(ga);
        end
    endtask

    task automatic drain(input int max_ticks, output int n);
        n = 0;
        while (exp_out_q.size() != 0 && n < max_ticks) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_out_q.size(), 0);
    endtask

    task automatic push_out(input logic [31:0] pc);
        exp_out_q.push_back({pc, mem_word(pc)});
    endtask

    // scoreboard monitor
    initial begin
        logic [31:0] ea;
        logic [63:0] eo;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                if (o_imem_req && i_imem_gnt) begin
                    if (exp_addr_q.size() == 0) begin
                        check("unexpected_grant_addr", o_imem_addr, 32'hxxxx_xxxx);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("grant_addr", o_imem_addr, ea);
                    end
                end
                if (o_instr_valid && i_instr_ready && !i_B_J_result[0]) begin
                    if (exp_out_q.size() == 0) begin
                        check("unexpected_instr_pc", o_pc, 32'hxxxx_xxxx);
                    end else begin
                        eo = exp_out_q.pop_front();
                        check("out_pc", o_pc, eo[63:32]);
                        check("out_instr", o_instr, eo[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        i_rst_n       = 1'b0;
        i_B_J_result  = 2'b00;
        i_target      = 32'h0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        i_instr_ready = 1'b1;
        mem_auto      = 1;
        mem_budget    = 0;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_req", o_imem_req, 0);
        check("rst_valid", o_instr_valid, 0);
        check("rst_instr", o_instr, 32'h0000_0013);
        check("rst_pc", o_pc, 32'h0);
        check("rst_state", o_dbg_state, ST_REQ);

        // 1: back-to-back fetch from reset
        mem_budget = 3;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
        push_out(32'h0); push_out(32'h4); push_out(32'h8);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        drain(40, n);
        check("t1_cycles_for_3_words", n, 7);

        // 2: decode stall with full buffer
        i_instr_ready = 1'b0;
        mem_budget = 1;
        exp_addr_q.push_back(32'hC);
        push_out(32'hC);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t2_req_low", o_imem_req, 0);
            check("t2_valid_held", o_instr_valid, 1);
            check("t2_pc_held", o_pc, 32'hC);
            check("t2_instr_held", o_instr, mem_word(32'hC));
            check("t2_no_pc_advance", o_imem_addr, 32'h10);
            tick();
        end
        i_instr_ready = 1'b1;
        drain(10, n);

        // 3: redirect while waiting for data, rvalid two cycles later
        mem_auto = 0;
        i_imem_gnt = 1'b1;
        exp_addr_q.push_back(32'h10);
        tick();
        check("t3_state_wait", o_dbg_state, ST_WAIT);
        i_B_J_result = 2'b01;
        i_target = 32'h100;
        tick();
        check("t3_state_flush", o_dbg_state, ST_FLUSH);
        check("t3_req_low", o_imem_req, 0);
        check("t3_addr_target", o_imem_addr, 32'h100);
        check("t3_valid_low", o_instr_valid, 0);
        tick();
        check("t3_still_flush", o_dbg_state, ST_FLUSH);
        i_imem_rvalid = 1'b1;
        i_imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("t3_state_req", o_dbg_state, ST_REQ);
        check("t3_req_high", o_imem_req, 1);
        check("t3_addr_0x100", o_imem_addr, 32'h100);
        check("t3_valid_low_after", o_instr_valid, 0);
        mem_auto = 1;
        mem_budget = 1;
        exp_addr_q.push_back(32'h100);
        push_out(32'h100);
        drain(10, n);

        // 4: redirect to misaligned target in the same cycle as a grant
        mem_auto = 0;
        i_imem_gnt = 1'b1;
        i_B_J_result = 2'b11;
        i_target = 32'h203;
        exp_addr_q.push_back(32'h104);
        tick();
        check("t4_state_flush", o_dbg_state, ST_FLUSH);
        check("t4_req_low", o_imem_req, 0);
        check("t4_addr_aligned", o_imem_addr, 32'h200);
        i_imem_rvalid = 1'b1;
        i_imem_rdata = 32'hBAD0_0001;
        tick();
        check("t4_state_req", o_dbg_state, ST_REQ);
        check("t4_req_high", o_imem_req, 1);
        check("t4_addr_0x200", o_imem_addr, 32'h200);
        check("t4_valid_low", o_instr_valid, 0);
        mem_auto = 1;
        mem_budget = 1;
        exp_addr_q.push_back(32'h200);
        push_out(32'h200);
        drain(10, n);

        // 5: redirect while the buffer is being accepted
        i_instr_ready = 1'b0;
        mem_budget = 1;
        exp_addr_q.push_back(32'h204);
        tick();
        tick();
        check("t5_valid_before", o_instr_valid, 1);
        check("t5_pc_before", o_pc, 32'h204);
        i_instr_ready = 1'b1;
        i_B_J_result = 2'b01;
        i_target = 32'h300;
        tick();
        check("t5_valid_squashed", o_instr_valid, 0);
        check("t5_addr_target", o_imem_addr, 32'h300);
        check("t5_state_req", o_dbg_state, ST_REQ);
        mem_budget = 1;
        exp_addr_q.push_back(32'h300);
        push_out(32'h300);
        drain(10, n);

        // 6: PC wrap, then async reset while waiting for data
        i_B_J_result = 2'b01;
        i_target = 32'hFFFF_FFFC;
        tick();
        check("t6_addr_top", o_imem_addr, 32'hFFFF_FFFC);
        mem_budget = 2;
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0);
        push_out(32'hFFFF_FFFC);
        push_out(32'h0);
        drain(20, n);
        check("t6_addr_after_wrap", o_imem_addr, 32'h4);
        mem_auto = 0;
        i_imem_gnt = 1'b1;
        exp_addr_q.push_back(32'h4);
        tick();
        check("t6_state_wait", o_dbg_state, ST_WAIT);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t6_rst_req", o_imem_req, 0);
        check("t6_rst_valid", o_instr_valid, 0);
        check("t6_rst_pc", o_pc, 32'h0);
        check("t6_rst_instr", o_instr, 32'h0000_0013);
        check("t6_rst_state", o_dbg_state, ST_REQ);
        check("t6_rst_addr", o_imem_addr, 32'h0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_imem_rvalid = 1'b1;
        i_imem_rdata = 32'hBADB_AD00;
        tick();
        check("t6_late_rvalid_state", o_dbg_state, ST_REQ);
        check("t6_late_rvalid_valid", o_instr_valid, 0);
        check("t6_late_rvalid_addr", o_imem_addr, 32'h0);
        tick();
        check("t6_still_empty", o_instr_valid, 0);

        check("addr_queue_empty", exp_addr_q.size(), 0);
        check("out_queue_empty", exp_out_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
